// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the controller/datapath and the
// iterative multiply/divide unit.
//   start  : request, sampled only while the unit is idle
//   MDOp   : 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7 reserved
//   A, B   : rs / rt operands
//   busy   : iterative operation in progress
//   done   : one-cycle pulse when HI/LO receive a mult/div result
//   hi, lo : architectural HI/LO registers (for MFHI/MFLO)
// master = requester (controller side), slave = mdu.
interface mdu_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, MDOp, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, MDOp, A, B,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit with architectural HI/LO.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_if.slave (start/MDOp/A/B in, busy/done/hi/lo out)
// MULT/MULTU/DIV/DIVU run 32 iterations (one per cycle) on operand
// magnitudes; signs are applied when HI/LO are written on the final edge.
// MTHI/MTLO write HI/LO directly from A in one cycle while idle.
module mdu (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;         // negate product / quotient
  logic        rem_neg_q, rem_neg_d; // remainder takes sign of dividend
  logic        dz_q, dz_d;           // divide by zero
  logic [31:0] opd_q, opd_d;         // multiplicand or divisor magnitude
  logic [63:0] prod_q, prod_d;       // {partial sum, remaining multiplier}
  logic [31:0] rem_q, rem_d;         // partial remainder
  logic [31:0] quo_q, quo_d;         // dividend bits shifting out, quotient in
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [63:0] prod_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes for the request currently presented
  always_comb begin
    signed_op = (bus.MDOp == OP_MULT) || (bus.MDOp == OP_DIV);
    a_mag     = (signed_op && bus.A[31]) ? -bus.A : bus.A;
    b_mag     = (signed_op && bus.B[31]) ? -bus.B : bus.B;
  end

  // One datapath iteration and the signed result fix-up
  always_comb begin
    // shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right
    mul_sum  = {1'b0, prod_q[63:32]} + {1'b0, opd_q};
    mul_next = prod_q[0] ? {mul_sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};

    // restoring divide: the shifted remainder is 33 bits wide, but any
    // accepted difference is below the divisor, so 32 bits hold it
    div_shift = {rem_q, quo_q[31]};
    div_ge    = (div_shift >= {1'b0, opd_q});
    div_diff  = div_shift[31:0] - opd_q;
    rem_next  = div_ge ? div_diff : div_shift[31:0];
    quo_next  = {quo_q[30:0], div_ge};

    prod_res = neg_q ? -mul_next : mul_next;
    // with a zero divisor every trial succeeds: the remainder ends as |A|
    // (restored to A by the sign rule) and only the quotient is forced
    quo_res  = dz_q ? '1 : (neg_q ? -quo_next : quo_next);
    rem_res  = rem_neg_q ? -rem_next : rem_next;
  end

  // Next-state / control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    opd_d     = opd_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.MDOp)
            OP_MULT, OP_MULTU: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              is_div_d  = 1'b0;
              neg_d     = signed_op && (bus.A[31] ^ bus.B[31]);
              rem_neg_d = 1'b0;
              dz_d      = 1'b0;
              opd_d     = a_mag;
              prod_d    = {32'd0, b_mag};
            end
            OP_DIV, OP_DIVU: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              neg_d     = signed_op && (bus.A[31] ^ bus.B[31]);
              rem_neg_d = signed_op && bus.A[31];
              dz_d      = (bus.B == '0);
              opd_d     = b_mag;
              rem_d     = '0;
              quo_d     = a_mag;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          rem_d = rem_next;
          quo_d = quo_next;
        end else begin
          prod_d = mul_next;
        end
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[63:32];
            lo_d = prod_res[31:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opd_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      opd_q     <= opd_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Fixed vectors with known results,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for MTHI/MTLO, ignored starts, back-to-back
// issue and reset during RUN.
module tb_mdu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // architectural HI/LO as the bench expects them to be
  logic [31:0] mhi;
  logic [31:0] mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit / native signed arithmetic, MIPS edge rules
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    rh = '0;
    rl = '0;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {rh, rl} = sp;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {rh, rl} = up;
      end
      3'd2: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF; rh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          rl = 32'h80000000; rh = 32'd0;
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          rl = sq; rh = sr;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF; rh = a;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one iterative op (start set in the current cycle) and follow it
  // until busy drops or the cycle budget runs out.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int cyc, output bit hold_ok, output bit dn);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    cyc     = 0;
    hold_ok = 1'b1;
    while (bus.busy && cyc < 100) begin
      if (bus.done || bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    rh = bus.hi;
    rl = bus.lo;
    dn = bus.done;
  endtask

  task automatic run_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit chk_drop);
    logic [31:0] rh;
    logic [31:0] rl;
    int cyc;
    bit hold;
    bit dn;
    do_op(op, a, b, rh, rl, cyc, hold, dn);
    chk({tag, " hi"}, rh, eh);
    chk({tag, " lo"}, rl, el);
    chk({tag, " busy_cycles"}, 32'(cyc), 32'd32);
    chk({tag, " done"}, {31'd0, dn}, 32'd1);
    chk({tag, " hold_in_run"}, {31'd0, hold}, 32'd1);
    mhi = eh;
    mlo = el;
    if (chk_drop) begin
      @(posedge clk); #1;
      chk({tag, " done_drop"}, {31'd0, bus.done}, 32'd0);
    end
  endtask

  task automatic run_ref(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit chk_drop);
    logic [31:0] eh;
    logic [31:0] el;
    ref_op(op, a, b, eh, el);
    run_exp(tag, op, a, b, eh, el, chk_drop);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          guard;
    bit          seen;

    tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4] = '{3'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    tbl[5] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    tbl[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[7] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    tbl[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[9] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    bus.start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    rst = 1'b0;
    mhi = '0;
    mlo = '0;

    // MTHI then MTLO: visible next cycle, no busy/done
    bus.start = 1'b1; bus.MDOp = 3'd4; bus.A = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("mthi hi", bus.hi, 32'hDEADBEEF);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    bus.MDOp = 3'd5; bus.A = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mtlo lo", bus.lo, 32'h0BADF00D);
    chk("mtlo hi kept", bus.hi, 32'hDEADBEEF);
    chk("mtlo done", {31'd0, bus.done}, 32'd0);
    mhi = 32'hDEADBEEF;
    mlo = 32'h0BADF00D;

    // reserved opcode: nothing changes
    bus.start = 1'b1; bus.MDOp = 3'd6; bus.A = 32'h55555555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rsvd busy", {31'd0, bus.busy}, 32'd0);
    chk("rsvd hi", bus.hi, mhi);
    chk("rsvd lo", bus.lo, mlo);

    foreach (tbl[i])
      run_exp($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].exp_hi, tbl[i].exp_lo, 1'b1);

    // start presented in the done cycle is accepted
    run_ref("b2b_first", 3'd1, 32'h00012345, 32'h00067890, 1'b0);
    run_ref("b2b_second", 3'd2, 32'hFFFFFF00, 32'd10, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_ref($sformatf("rnd%0d", n), rop, ra, rb, 1'b1);
    end

    // MTHI while RUN is ignored; HI holds until completion
    bus.start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.MDOp = 3'd4; bus.A = 32'h12345678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mthi_in_run hi", bus.hi, mhi);
    chk("mthi_in_run busy", {31'd0, bus.busy}, 32'd1);
    guard = 0;
    while (bus.busy && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("mthi_in_run wait", {31'd0, bus.busy}, 32'd0);
    chk("mthi_in_run done", {31'd0, bus.done}, 32'd1);
    chk("mthi_in_run res_hi", bus.hi, 32'd0);
    chk("mthi_in_run res_lo", bus.lo, 32'd15);
    @(posedge clk); #1;

    // reset during RUN aborts without a done pulse
    bus.start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'h00001234; bus.B = 32'h00005678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    chk("abort busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort quiet", {31'd0, seen}, 32'd0);
    mhi = '0;
    mlo = '0;

    run_ref("post_abort", 3'd3, 32'hFEDCBA98, 32'h00001000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS datapath, the multi-cycle counterpart to the single-cycle ALU. It takes the same two register-file operands and a 3-bit operation code from the controller, computes MULT/MULTU/DIV/DIVU over 32 cycles with a start/busy/done handshake, and holds the result in architectural HI/LO registers. It also services MTHI/MTLO. HI/LO are exported for MFHI/MFLO writeback muxing.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- MDOp  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (ignored).
- A  input  32  rs operand; dividend / multiplicand / MTHI-MTLO source.
- B  input  32  rt operand; divisor / multiplier.
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, RUN. Reset -> IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- IDLE, start=1, MDOp in 0..3: latch op, sign flags, magnitude operands (|A|,|B| for signed ops, raw for unsigned); counter=0; go RUN.
- IDLE, start=1, MDOp=4: hi<=A next edge; MDOp=5: lo<=A. No busy, no done, stay IDLE.
- IDLE, start=1, MDOp 6/7 or start=0: no state change.
- RUN: one iteration per cycle. Multiply: shift-add on 64-bit product of magnitudes. Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
- After 32nd iteration: write hi/lo, pulse done, return IDLE.
- Result mapping: MULT/MULTU {hi,lo}=64-bit product; product negated if signed and sign(A)^sign(B). DIV/DIVU lo=quotient, hi=remainder; signed: quotient negated if sign(A)^sign(B), remainder takes sign of A (truncating division).
- Divide by zero (B=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=A. Still takes full 32 cycles.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
- start while RUN: ignored, including MTHI/MTLO; A/B changes during RUN have no effect.
- hi/lo hold previous values throughout RUN; only updated on completion edge.
- rst in RUN: abort, outputs return to reset values next edge, no done.

## Timing
- Start sampled at edge E0 -> busy=1 after E0.
- Iterations on edges E1..E32; at E32 hi/lo written, done=1, busy=0 (both visible after E32, for exactly one cycle for done).
- Latency start-to-result: 32 cycles. New start accepted at E33 earliest (sampled when IDLE after E32); a start asserted in the done cycle is accepted.
- MTHI/MTLO: hi/lo updated at E0, visible next cycle.
- busy and done never high together.

## Test plan
- MULT A=32'hFFFFFFFD (-3), B=7 -> after 32 cycles done pulse, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high exactly 32 cycles.
- MULTU A=32'hFFFFFFFF, B=2 -> hi=32'h00000001, lo=32'hFFFFFFFE.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU A=32'h12345678, B=0 -> lo=32'hFFFFFFFF, hi=32'h12345678 after 32 cycles.
- MTHI A=32'hDEADBEEF then MTLO A=32'h0BADF00D -> hi/lo updated next cycle, busy/done stay 0; then MULT started and MTHI pulsed at cycle 10 of RUN -> ignored, hi unchanged until completion.
- MULT started, rst asserted at cycle 15 of RUN -> next cycle busy=0, done=0, hi=lo=0; no done pulse thereafter.
